multicycle_controller: RTL and testbench

- Multicycle Armv4 controller: sequences a shared-memory, single-ALU datapath over 3–5 cycles per instruction.
- Contains the main FSM, the instruction/ALU decode, the NZCV flags register and conditional-execution gating.
- Drives the multicycle datapath's mux selects and write enables. Replaces the single-cycle controller in the multicycle core.

---
 rtl/multicycle_controller_pkg.sv | 87 ++++++++
 rtl/multicycle_main_fsm.sv | 106 ++++++++++
 rtl/multicycle_controller.sv | 132 +++++++++++++
 tb/tb_multicycle_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle Armv4 controller: FSM states, datapath select codes,
// opcode/command constants, the per-state control bundle and the condition-code evaluator.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_control_t;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_DP      = 2'b00;
  localparam logic [1:0] IMM_MEM     = 2'b01;
  localparam logic [1:0] IMM_BRANCH  = 2'b10;

  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BRANCH   = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  localparam logic [3:0] CMD_AND     = 4'b0000;
  localparam logic [3:0] CMD_SUB     = 4'b0010;
  localparam logic [3:0] CMD_ADD     = 4'b0100;
  localparam logic [3:0] CMD_CMP     = 4'b1010;
  localparam logic [3:0] CMD_ORR     = 4'b1100;

  // Moore control bundle; the top turns the enable markers into gated write strobes.
  typedef struct packed {
    logic       fetch;
    logic       execute;
    logic       mem_write;
    logic       mem_wb;
    logic       alu_wb;
    logic       branch;
    logic       address_source;
    logic       alu_source_a;
    logic [1:0] alu_source_b;
    logic [1:0] result_source;
  } ctrl_t;

  function automatic logic condition_parser(input logic [3:0] flags, input logic [3:0] cond);
    logic n, z, c, v, ge, pass;
    {n, z, c, v} = flags;
    ge = (n == v);
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = ge;
      4'b1011: pass = ~ge;
      4'b1100: pass = ~z & ge;
      4'b1101: pass = z | ~ge;
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main sequencer: state register plus registered Moore control bundle, 3-5 cycles per instruction.
// With MULTICYCLE_MEMORY_WAIT_EN, FETCH/MEMREAD/MEMWRITE hold until memory_ready is high.
module multicycle_main_fsm
  import multicycle_controller_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   [1:0] op,
  input  logic   dp_immediate,
  input  logic   mem_load,
`ifdef MULTICYCLE_MEMORY_WAIT_EN
  input  logic   memory_ready,
`endif
  output state_t state,
  output ctrl_t  ctrl
);

  logic ready;
`ifdef MULTICYCLE_MEMORY_WAIT_EN
  assign ready = memory_ready;
`else
  assign ready = 1'b1;
`endif

  function automatic state_t next_of(input state_t s, input logic [1:0] o, input logic imm,
                                     input logic load, input logic rdy);
    state_t nxt;
    case (s)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (o)
          OP_MEM:    nxt = MEMADR;
          OP_DP:     nxt = imm ? EXECUTEI : EXECUTER;
          OP_BRANCH: nxt = BRANCH;
          default:   nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = load ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
    return nxt;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch         = 1'b1;
        c.alu_source_a  = 1'b1;
        c.alu_source_b  = SRCB_FOUR;
        c.result_source = RES_ALU;
      end
      DECODE: begin
        c.alu_source_a  = 1'b1;
        c.alu_source_b  = SRCB_FOUR;
        c.result_source = RES_ALU;
      end
      MEMADR:   c.alu_source_b = SRCB_IMM;
      MEMREAD:  c.address_source = 1'b1;
      MEMWB: begin
        c.mem_wb        = 1'b1;
        c.result_source = RES_MEMDATA;
      end
      MEMWRITE: begin
        c.mem_write      = 1'b1;
        c.address_source = 1'b1;
      end
      EXECUTER: begin
        c.execute      = 1'b1;
        c.alu_source_b = SRCB_RM;
      end
      EXECUTEI: begin
        c.execute      = 1'b1;
        c.alu_source_b = SRCB_IMM;
      end
      ALUWB: begin
        c.alu_wb        = 1'b1;
        c.result_source = RES_ALUOUT;
      end
      BRANCH: begin
        c.branch        = 1'b1;
        c.alu_source_b  = SRCB_IMM;
        c.result_source = RES_ALU;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // The bundle is registered from the next state so outputs come straight off flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ctrl  <= decode(FETCH);
    end else begin
      state <= next_of(state, op, dp_immediate, mem_load, ready);
      ctrl  <= decode(next_of(state, op, dp_immediate, mem_load, ready));
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle Armv4 controller: ALU decode, NZCV flags, condition gating around the main FSM.
// Optional MULTICYCLE_MEMORY_WAIT_EN adds memory_ready; memory states stall until it is high.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] instruction,
  input  logic [3:0]  ALU_flags,
`ifdef MULTICYCLE_MEMORY_WAIT_EN
  input  logic        memory_ready,
`endif
  output logic        pc_write,
  output logic        address_source,
  output logic        instruction_write,
  output logic        memory_write,
  output logic        register_write,
  output logic        ALU_source_a,
  output logic [1:0]  ALU_source_b,
  output logic [1:0]  result_source,
  output logic [1:0]  ALU_control,
  output logic [1:0]  immediate_source,
  output logic [1:0]  register_source,
  output logic [3:0]  state
);

  logic [3:0] cond_field;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond_field = instruction[19:16];
  assign op         = instruction[15:14];
  assign funct      = instruction[13:8];
  assign unused_rn  = ^instruction[7:4];
  assign rd         = instruction[3:0];

  logic ready;
`ifdef MULTICYCLE_MEMORY_WAIT_EN
  assign ready = memory_ready;
`else
  assign ready = 1'b1;
`endif

  state_t fsm_state;
  ctrl_t  ctrl;

  multicycle_main_fsm u_main_fsm (
    .clock        (clock),
    .reset        (reset),
    .op           (op),
    .dp_immediate (funct[5]),
    .mem_load     (funct[0]),
`ifdef MULTICYCLE_MEMORY_WAIT_EN
    .memory_ready (memory_ready),
`endif
    .state        (fsm_state),
    .ctrl         (ctrl)
  );

  alu_control_t alu_decoded;
  logic         dp_writes;
  logic         dp_known;
  logic         dp_arith;

  // Unrecognised commands run as ADD but touch neither the register file nor the flags.
  always_comb begin
    alu_decoded = ALU_ADD;
    dp_writes   = 1'b0;
    dp_known    = 1'b1;
    dp_arith    = 1'b0;
    case (funct[4:1])
      CMD_ADD: begin
        dp_writes = 1'b1;
        dp_arith  = 1'b1;
      end
      CMD_SUB: begin
        alu_decoded = ALU_SUB;
        dp_writes   = 1'b1;
        dp_arith    = 1'b1;
      end
      CMD_AND: begin
        alu_decoded = ALU_AND;
        dp_writes   = 1'b1;
      end
      CMD_ORR: begin
        alu_decoded = ALU_ORR;
        dp_writes   = 1'b1;
      end
      CMD_CMP: begin
        alu_decoded = ALU_SUB;
        dp_arith    = 1'b1;
      end
      default: dp_known = 1'b0;
    endcase
  end

  logic [3:0] flags;
  logic       cond;
  logic       flag_write;

  assign cond       = condition_parser(flags, cond_field);
  assign flag_write = ctrl.execute & funct[0] & cond & dp_known;

  // N/Z and C/V are separate enabled flops: logical ops leave carry and overflow alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      if (flag_write)            flags[3:2] <= ALU_flags[3:2];
      if (flag_write & dp_arith) flags[1:0] <= ALU_flags[1:0];
    end
  end

  logic pc_from_alu;
  assign pc_from_alu = ctrl.alu_wb & cond & dp_writes & (rd == 4'hF);

  assign pc_write          = reset & ((ctrl.fetch & ready) | (ctrl.branch & cond) | pc_from_alu);
  assign instruction_write = reset & ctrl.fetch & ready;
  assign memory_write      = reset & ctrl.mem_write & cond & ready;
  assign register_write    = reset & cond & (ctrl.mem_wb | (ctrl.alu_wb & dp_writes));
  assign address_source    = reset & ctrl.address_source;
  assign ALU_source_a      = reset & ctrl.alu_source_a;
  assign ALU_source_b      = {2{reset}} & ctrl.alu_source_b;
  assign result_source     = {2{reset}} & ctrl.result_source;
  assign ALU_control       = (reset && ctrl.execute) ? alu_decoded : ALU_ADD;
  assign immediate_source  = {2{reset}} & op;
  assign register_source   = {2{reset}} & {(op == OP_MEM) & ~funct[0], op == OP_BRANCH};
  assign state             = fsm_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors are queued
// with each instruction and compared at the falling edge by a monitor.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic        clock;
  logic        reset;
  logic [19:0] instruction;
  logic [3:0]  ALU_flags;
`ifdef MULTICYCLE_MEMORY_WAIT_EN
  logic        memory_ready;
`endif
  logic        pc_write, address_source, instruction_write, memory_write, register_write, ALU_source_a;
  logic [1:0]  ALU_source_b, result_source, ALU_control, immediate_source, register_source;
  logic [3:0]  state;

  multicycle_controller dut (
    .clock             (clock),
    .reset             (reset),
    .instruction       (instruction),
    .ALU_flags         (ALU_flags),
`ifdef MULTICYCLE_MEMORY_WAIT_EN
    .memory_ready      (memory_ready),
`endif
    .pc_write          (pc_write),
    .address_source    (address_source),
    .instruction_write (instruction_write),
    .memory_write      (memory_write),
    .register_write    (register_write),
    .ALU_source_a      (ALU_source_a),
    .ALU_source_b      (ALU_source_b),
    .result_source     (result_source),
    .ALU_control       (ALU_control),
    .immediate_source  (immediate_source),
    .register_source   (register_source),
    .state             (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [19:0] act;
  assign act = {state, pc_write, instruction_write, memory_write, register_write, address_source,
                ALU_source_a, ALU_source_b, result_source, ALU_control, immediate_source, register_source};

  // Expected vector: select values from the per-state table, enables supplied by the caller.
  function automatic logic [19:0] mk(input state_t st, input logic pcw, input logic irw, input logic mw,
                                     input logic rw, input logic [1:0] ac, input logic [1:0] is,
                                     input logic [1:0] rsrc);
    logic       adr, sa;
    logic [1:0] srcb, res;
    adr = 1'b0; sa = 1'b0; srcb = 2'b00; res = 2'b00;
    case (st)
      FETCH, DECODE: begin sa = 1'b1; srcb = 2'b10; res = 2'b10; end
      MEMADR, EXECUTEI: srcb = 2'b01;
      MEMREAD, MEMWRITE: adr = 1'b1;
      MEMWB: res = 2'b01;
      BRANCH: begin srcb = 2'b01; res = 2'b10; end
      default: ;
    endcase
    return {st, pcw, irw, mw, rw, adr, sa, srcb, res, ac, is, rsrc};
  endfunction

  function automatic logic [19:0] ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                      input logic [3:0] rd);
    return {c, o, f, 4'h2, rd};
  endfunction

  task automatic push(input string tag, input logic [19:0] v);
    exp_t e;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_fd(input string tag, input logic [1:0] is, input logic [1:0] rsrc);
    push({tag, ".fetch"}, mk(FETCH, 1, 1, 0, 0, 2'b00, is, rsrc));
    push({tag, ".decode"}, mk(DECODE, 0, 0, 0, 0, 2'b00, is, rsrc));
  endtask

  // Entered just after a rising edge; applies the instruction for n cycles.
  task automatic run(input logic [19:0] i, input logic [3:0] fl, input int n);
    instruction = i;
    ALU_flags = fl;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.tag, act, e.v);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b0;
    instruction = 20'h0;
    ALU_flags = 4'h0;
    @(negedge clock);
    vectors++;
    if (act !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", act, 20'h0);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (act !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_after_edge: got %h want %h", act, 20'h0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (act !== mk(FETCH, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00)) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", act, mk(FETCH, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00));
    end
  endtask

  task automatic test_data_processing;
    push_fd("add", 2'b00, 2'b00);
    push("add.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("add.wb", mk(ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b001000, 4'd1), 4'h0, 4);
    push_fd("addpc", 2'b00, 2'b00);
    push("addpc.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("addpc.wb", mk(ALUWB, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b001000, 4'd15), 4'h0, 4);
    push_fd("addnv", 2'b00, 2'b00);
    push("addnv.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("addnv.wb", mk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run(ins(4'hF, 2'b00, 6'b001000, 4'd1), 4'h0, 4);
    push_fd("nop", 2'b11, 2'b00);
    run(ins(4'hE, 2'b11, 6'b000000, 4'd0), 4'h0, 2);
  endtask

  task automatic test_memory;
    push_fd("ldr", 2'b01, 2'b00);
    push("ldr.adr", mk(MEMADR, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    push("ldr.read", mk(MEMREAD, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    push("ldr.wb", mk(MEMWB, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00));
    run(ins(4'hE, 2'b01, 6'b011001, 4'd4), 4'h0, 5);
    push_fd("str", 2'b01, 2'b10);
    push("str.adr", mk(MEMADR, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10));
    push("str.write", mk(MEMWRITE, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10));
    run(ins(4'hE, 2'b01, 6'b011000, 4'd4), 4'h0, 4);
  endtask

  task automatic test_branch;
    push_fd("subs", 2'b00, 2'b00);
    push("subs.exec", mk(EXECUTEI, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    push("subs.wb", mk(ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b100101, 4'd0), 4'b0100, 4);
    push_fd("beq", 2'b10, 2'b01);
    push("beq.branch", mk(BRANCH, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    run(ins(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, 3);
    push_fd("bne", 2'b10, 2'b01);
    push("bne.branch", mk(BRANCH, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    run(ins(4'h1, 2'b10, 6'b100000, 4'd0), 4'h0, 3);
  endtask

  task automatic test_cmp_flags;
    push_fd("cmp", 2'b00, 2'b00);
    push("cmp.exec", mk(EXECUTEI, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    push("cmp.wb", mk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b110101, 4'd1), 4'b1000, 4);
    push_fd("orrmi", 2'b00, 2'b00);
    push("orrmi.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    push("orrmi.wb", mk(ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'h4, 2'b00, 6'b011000, 4'd2), 4'h0, 4);
    push_fd("andpl", 2'b00, 2'b00);
    push("andpl.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));
    push("andpl.wb", mk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run(ins(4'h5, 2'b00, 6'b000000, 4'd2), 4'h0, 4);
    // ANDS: N,Z from ALU (0,1); C,V must keep 0,0 despite ALU offering 1,1.
    push_fd("ands", 2'b00, 2'b00);
    push("ands.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));
    push("ands.wb", mk(ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b000001, 4'd3), 4'b0111, 4);
    push_fd("bcs", 2'b10, 2'b01);
    push("bcs.branch", mk(BRANCH, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    run(ins(4'h2, 2'b10, 6'b100000, 4'd0), 4'h0, 3);
    push_fd("beq2", 2'b10, 2'b01);
    push("beq2.branch", mk(BRANCH, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    run(ins(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, 3);
    // Unknown command with S set: no register write and Z must survive.
    push_fd("eors", 2'b00, 2'b00);
    push("eors.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("eors.wb", mk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run(ins(4'hE, 2'b00, 6'b000011, 4'd3), 4'b0000, 4);
    push_fd("beq3", 2'b10, 2'b01);
    push("beq3.branch", mk(BRANCH, 1, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    run(ins(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, 3);
  endtask

  task automatic test_reset_mid_instruction;
    push_fd("strr", 2'b01, 2'b10);
    push("strr.adr", mk(MEMADR, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10));
    run(ins(4'hE, 2'b01, 6'b011000, 4'd4), 4'h0, 3);
    vectors++;
    if ({state, memory_write, address_source} !== {MEMWRITE, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL strr.memwrite: got %h want %h", {state, memory_write, address_source},
               {MEMWRITE, 1'b1, 1'b1});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (act !== 20'h0) begin
      miscompares++;
      $display("FAIL strr.abort: got %h want %h", act, 20'h0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    // Flags were 0100 before the reset; EQ must now fail and NE pass.
    push_fd("addeq", 2'b00, 2'b00);
    push("addeq.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("addeq.wb", mk(ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run(ins(4'h0, 2'b00, 6'b001000, 4'd1), 4'h0, 4);
    push_fd("addne", 2'b00, 2'b00);
    push("addne.exec", mk(EXECUTER, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    push("addne.wb", mk(ALUWB, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    run(ins(4'h1, 2'b00, 6'b001000, 4'd1), 4'h0, 4);
  endtask

`ifdef MULTICYCLE_MEMORY_WAIT_EN
  task automatic test_memory_wait;
    for (int k = 0; k < 3; k++) push("wait.fetch_stall", mk(FETCH, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    push_fd("wait", 2'b11, 2'b00);
    memory_ready = 1'b0;
    run(ins(4'hE, 2'b11, 6'b000000, 4'd0), 4'h0, 3);
    memory_ready = 1'b1;
    run(ins(4'hE, 2'b11, 6'b000000, 4'd0), 4'h0, 2);
    push_fd("wstr", 2'b01, 2'b10);
    push("wstr.adr", mk(MEMADR, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10));
    for (int k = 0; k < 2; k++) push("wstr.stall", mk(MEMWRITE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10));
    push("wstr.write", mk(MEMWRITE, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10));
    run(ins(4'hE, 2'b01, 6'b011000, 4'd4), 4'h0, 3);
    memory_ready = 1'b0;
    run(ins(4'hE, 2'b01, 6'b011000, 4'd4), 4'h0, 2);
    memory_ready = 1'b1;
    run(ins(4'hE, 2'b01, 6'b011000, 4'd4), 4'h0, 1);
  endtask
`endif

  initial begin
`ifdef MULTICYCLE_MEMORY_WAIT_EN
    memory_ready = 1'b1;
`endif
    test_reset;
    test_data_processing;
    test_memory;
    test_branch;
    test_cmp_flags;
    test_reset_mid_instruction;
`ifdef MULTICYCLE_MEMORY_WAIT_EN
    test_memory_wait;
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
